multicycle_control_unit: RTL and testbench

Multicycle successor to the single-cycle RV32I control unit. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It waits on a memory-ready handshake and adds optional RV32M multiply/divide with a programmable stall counter. It sits between the instruction register (IR) and the shared datapath (PC, register unit, ALU, unified memory port), and raises a sticky trap on illegal opcodes.

---
 rtl/multicycle_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-ready handshake, a counted MULDIV stall and a sticky illegal-opcode trap.
module multicycle_control_unit #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          MUL_EXT     = 1'b1,
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OpCode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       MemRd,
  output logic       DMWr,
  output logic       RUWr,
  output logic       AlUASrc,
  output logic       AlUBSrc,
  output logic [1:0] RUDataWrSrc,
  output logic [2:0] DMCtrl,
  output logic [2:0] ImmSrc,
  output logic [4:0] ALUOp,
  output logic [4:0] BrOp,
  output logic       busy,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q;
  logic       illegal_q;
  logic       rdy;
  logic       is_r, is_imm, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic       is_m, f7_ok, legal;
  logic       pc_wr, ir_wr, mem_rd, dm_wr, ru_wr;

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    is_r     = (OpCode == OP_R);
    is_imm   = (OpCode == OP_IMM);
    is_load  = (OpCode == OP_LOAD);
    is_store = (OpCode == OP_STORE);
    is_br    = (OpCode == OP_BR);
    is_jal   = (OpCode == OP_JAL);
    is_jalr  = (OpCode == OP_JALR);
    is_lui   = (OpCode == OP_LUI);
    is_auipc = (OpCode == OP_AUIPC);
    is_m     = is_r && (Funct7 == 7'b0000001);
    f7_ok    = (Funct7 == 7'b0000000) || (Funct7 == 7'b0100000) ||
               ((Funct7 == 7'b0000001) && MUL_EXT);
    legal    = (is_r && f7_ok) || is_imm || is_load || is_store || is_br ||
               is_jal || is_jalr || is_lui || is_auipc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP)
        illegal_q <= 1'b1;
      if (state_q == S_DECODE && state_d == S_MULDIV)
        cnt_q <= Funct3[2] ? DIV_LOAD : MUL_LOAD;
      else if (state_q == S_MULDIV && cnt_q != '0)
        cnt_q <= cnt_q - 6'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    mem_rd  = 1'b0;
    dm_wr   = 1'b0;
    ru_wr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (rdy) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal)    state_d = S_TRAP;
        else if (is_m) state_d = S_MULDIV;
        else           state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_br) begin
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_rd = is_load;
        dm_wr  = is_store;
        if (rdy) begin
          if (is_store) begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MULDIV: begin
        if (cnt_q == '0) state_d = S_WB;
      end
      S_WB: begin
        ru_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are forced low combinationally so nothing fires during the reset cycle itself.
  assign PCWr  = pc_wr  & ~rst;
  assign IRWr  = ir_wr  & ~rst;
  assign MemRd = mem_rd & ~rst;
  assign DMWr  = dm_wr  & ~rst;
  assign RUWr  = ru_wr  & ~rst;

  always_comb begin
    AlUASrc     = 1'b0;
    AlUBSrc     = 1'b0;
    RUDataWrSrc = 2'b00;
    DMCtrl      = 3'b000;
    ImmSrc      = 3'b000;
    ALUOp       = 5'b00000;
    BrOp        = 5'b00000;
    if (state_q != S_FETCH) begin
      AlUASrc = is_auipc | is_jal | is_br;
      AlUBSrc = ~is_r;
      if (is_load)               RUDataWrSrc = 2'b01;
      else if (is_jal | is_jalr) RUDataWrSrc = 2'b10;
      if (is_load | is_store) DMCtrl = Funct3;
      if (is_store)                ImmSrc = 3'b001;
      else if (is_br)              ImmSrc = 3'b101;
      else if (is_lui | is_auipc)  ImmSrc = 3'b010;
      else if (is_jal)             ImmSrc = 3'b110;
      if (is_r)
        ALUOp = {is_m, ~is_m & Funct7[5], Funct3};
      else if (is_imm)
        ALUOp = {1'b0, (Funct3 == 3'b101) & Funct7[5], Funct3};
      if (is_br)                 BrOp = {2'b01, Funct3};
      else if (is_jal | is_jalr) BrOp = 5'b10000;
    end
  end

  assign busy    = (state_q == S_MULDIV);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class cycle by
// cycle and checks state, enables and datapath selects against hand-derived values.
module tb_multicycle_control_unit;

  logic       clk, rst, mem_ready;
  logic [6:0] OpCode, Funct7;
  logic [2:0] Funct3;

  logic       PCWr, IRWr, MemRd, DMWr, RUWr, AlUASrc, AlUBSrc, busy, illegal;
  logic [1:0] RUDataWrSrc;
  logic [2:0] DMCtrl, ImmSrc, state;
  logic [4:0] ALUOp, BrOp;

  logic       pc_wr2, ir_wr2, mem_rd2, dm_wr2, ru_wr2, a_src2, b_src2, busy2, illegal2;
  logic [1:0] wr_src2;
  logic [2:0] dm_ctrl2, imm_src2, state2;
  logic [4:0] alu_op2, br_op2;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.MEM_WAIT_EN(1'b1), .MUL_EXT(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .DMWr(DMWr),
    .RUWr(RUWr), .AlUASrc(AlUASrc), .AlUBSrc(AlUBSrc), .RUDataWrSrc(RUDataWrSrc),
    .DMCtrl(DMCtrl), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .BrOp(BrOp), .busy(busy),
    .illegal(illegal), .state(state)
  );

  multicycle_control_unit #(.MEM_WAIT_EN(1'b1), .MUL_EXT(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut_nom (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .mem_ready(mem_ready), .PCWr(pc_wr2), .IRWr(ir_wr2), .MemRd(mem_rd2), .DMWr(dm_wr2),
    .RUWr(ru_wr2), .AlUASrc(a_src2), .AlUBSrc(b_src2), .RUDataWrSrc(wr_src2),
    .DMCtrl(dm_ctrl2), .ImmSrc(imm_src2), .ALUOp(alu_op2), .BrOp(br_op2), .busy(busy2),
    .illegal(illegal2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // en = {PCWr, IRWr, MemRd, DMWr, RUWr}
  task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] en);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".en"}, 32'({PCWr, IRWr, MemRd, DMWr, RUWr}), 32'(en));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    OpCode = op;
    Funct3 = f3;
    Funct7 = f7;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    instr(7'b0, 3'b0, 7'b0);
    nxt(); nxt();
    cyc("rst", 3'd0, 5'b00000);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    // add x3,x1,x2
    rst = 1'b0;
    instr(7'b0110011, 3'b000, 7'b0000000);
    cyc("add.f", 3'd0, 5'b01100);
    chk("add.f.aluop", 32'(ALUOp), 32'd0);
    nxt(); cyc("add.d", 3'd1, 5'b00000);
    chk("add.d.aluop", 32'(ALUOp), 32'd0);
    nxt(); cyc("add.e", 3'd2, 5'b00000);
    nxt(); cyc("add.w", 3'd4, 5'b10001);
    chk("add.w.wrsrc", 32'(RUDataWrSrc), 32'd0);
    chk("add.w.bsrc", 32'(AlUBSrc), 32'd0);
    nxt();

    // sub and srai exercise the Funct7[5] qualifier
    instr(7'b0110011, 3'b000, 7'b0100000);
    cyc("sub.f", 3'd0, 5'b01100);
    nxt(); cyc("sub.d", 3'd1, 5'b00000);
    chk("sub.aluop", 32'(ALUOp), 32'h08);
    nxt(); nxt(); nxt();
    instr(7'b0010011, 3'b101, 7'b0100000);
    nxt(); cyc("srai.d", 3'd1, 5'b00000);
    chk("srai.aluop", 32'(ALUOp), 32'h0D);
    chk("srai.bsrc", 32'(AlUBSrc), 32'd1);
    nxt(); nxt(); cyc("srai.w", 3'd4, 5'b10001);
    nxt();

    // lw with three wait cycles in MEM
    instr(7'b0000011, 3'b010, 7'b0000000);
    cyc("lw.f", 3'd0, 5'b01100);
    nxt(); cyc("lw.d", 3'd1, 5'b00000);
    chk("lw.dmctrl", 32'(DMCtrl), 32'd2);
    nxt(); cyc("lw.e", 3'd2, 5'b00000);
    nxt(); mem_ready = 1'b0;
    cyc("lw.m1", 3'd3, 5'b00100);
    nxt(); cyc("lw.m2", 3'd3, 5'b00100);
    nxt(); cyc("lw.m3", 3'd3, 5'b00100);
    nxt(); mem_ready = 1'b1;
    cyc("lw.m4", 3'd3, 5'b00100);
    nxt(); cyc("lw.w", 3'd4, 5'b10001);
    chk("lw.wrsrc", 32'(RUDataWrSrc), 32'd1);
    nxt(); cyc("lw.next", 3'd0, 5'b01100);

    // mul: 4 busy cycles
    instr(7'b0110011, 3'b000, 7'b0000001);
    nxt(); cyc("mul.d", 3'd1, 5'b00000);
    chk("mul.d.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); cyc("mul.md", 3'd5, 5'b00000);
      chk("mul.busy", 32'(busy), 32'd1);
      chk("mul.aluop", 32'(ALUOp), 32'h10);
    end
    nxt(); cyc("mul.w", 3'd4, 5'b10001);
    chk("mul.w.busy", 32'(busy), 32'd0);
    nxt();

    // div: 32 busy cycles
    instr(7'b0110011, 3'b100, 7'b0000001);
    cyc("div.f", 3'd0, 5'b01100);
    nxt(); cyc("div.d", 3'd1, 5'b00000);
    for (int i = 0; i < 32; i++) begin
      nxt(); cyc("div.md", 3'd5, 5'b00000);
      chk("div.aluop", 32'(ALUOp), 32'h14);
    end
    nxt(); cyc("div.w", 3'd4, 5'b10001);
    nxt();

    // beq
    instr(7'b1100011, 3'b000, 7'b0000000);
    cyc("beq.f", 3'd0, 5'b01100);
    chk("beq.f.brop", 32'(BrOp), 32'd0);
    nxt(); cyc("beq.d", 3'd1, 5'b00000);
    nxt(); cyc("beq.e", 3'd2, 5'b10000);
    chk("beq.brop", 32'(BrOp), 32'h08);
    chk("beq.asrc", 32'(AlUASrc), 32'd1);
    chk("beq.imm", 32'(ImmSrc), 32'd5);
    nxt(); cyc("beq.next", 3'd0, 5'b01100);

    // sw
    instr(7'b0100011, 3'b010, 7'b0000000);
    nxt(); cyc("sw.d", 3'd1, 5'b00000);
    nxt(); cyc("sw.e", 3'd2, 5'b00000);
    nxt(); cyc("sw.m", 3'd3, 5'b10010);
    chk("sw.imm", 32'(ImmSrc), 32'd1);
    nxt(); cyc("sw.next", 3'd0, 5'b01100);

    // jal
    instr(7'b1101111, 3'b000, 7'b0000000);
    nxt(); cyc("jal.d", 3'd1, 5'b00000);
    nxt(); cyc("jal.e", 3'd2, 5'b00000);
    nxt(); cyc("jal.w", 3'd4, 5'b10001);
    chk("jal.wrsrc", 32'(RUDataWrSrc), 32'd2);
    chk("jal.brop", 32'(BrOp), 32'h10);
    nxt();

    // illegal opcode traps until reset
    instr(7'b1110011, 3'b000, 7'b0000000);
    cyc("trap.f", 3'd0, 5'b01100);
    nxt(); cyc("trap.d", 3'd1, 5'b00000);
    chk("trap.d.illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 10; i++) begin
      nxt(); cyc("trap.hold", 3'd6, 5'b00000);
      chk("trap.illegal", 32'(illegal), 32'd1);
    end
    rst = 1'b1;
    cyc("trap.rst", 3'd6, 5'b00000);
    nxt(); rst = 1'b0;
    instr(7'b0110011, 3'b100, 7'b0000001);
    cyc("trap.clr", 3'd0, 5'b01100);
    chk("trap.clr.illegal", 32'(illegal), 32'd0);

    // reset in cycle 10 of a div
    nxt(); cyc("divr.d", 3'd1, 5'b00000);
    for (int i = 0; i < 7; i++) begin
      nxt(); cyc("divr.md", 3'd5, 5'b00000);
    end
    nxt(); rst = 1'b1;
    cyc("divr.c10", 3'd5, 5'b00000);
    nxt(); rst = 1'b0;
    instr(7'b0110011, 3'b000, 7'b0000001);
    cyc("divr.after", 3'd0, 5'b01100);
    chk("divr.busy", 32'(busy), 32'd0);

    // mul on the MUL_EXT=0 instance traps
    chk("nom.f.state", 32'(state2), 32'd0);
    nxt(); cyc("nom.d", 3'd1, 5'b00000);
    chk("nom.d.state", 32'(state2), 32'd1);
    nxt(); #1;
    chk("nom.trap.state", 32'(state2), 32'd6);
    chk("nom.trap.illegal", 32'(illegal2), 32'd1);
    chk("nom.trap.en", 32'({pc_wr2, ir_wr2, mem_rd2, dm_wr2, ru_wr2}), 32'd0);
    chk("ext.muldiv.state", 32'(state), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
